// File: rtl/mem_wr_queue.sv
// mem_wr_queue
// Write-side buffer between the ECC data encoder and the ECC SRAM port.
// Holds up to DEPTH pending codeword writes and drains them into memory
// whenever the read path leaves the port idle. Reads have priority, but a
// write that has been deferred STARVE_LIMIT consecutive cycles is forced.
//
// Build option: define WRQ_FWD_EN to enable read forwarding from queued
// entries (fwd_hit_o / fwd_data_o). Without it, a read whose address matches
// a queued entry is stalled until the matching writes have drained.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_en_i, wr_addr_i,        push request, word address, 39-bit codeword
//   encoded_data_i
//   wr_full_o, ovf_o           queue full, sticky push-while-full flag
//   rd_req_i, rd_addr_i        read request and word address
//   rd_stall_o                 read not issued this cycle, retry
//   fwd_hit_o, fwd_data_o      youngest queued codeword matching rd_addr_i
//   mem_en_o, mem_we_o,        SRAM port (combinational)
//   mem_addr_o, mem_wdata_o
//   count_o                    occupancy
module mem_wr_queue #(
  parameter int MEMORY_DATA_WIDTH = 39,
  parameter int ADDR_WIDTH        = 14,
  parameter int DEPTH             = 4,
  parameter int STARVE_LIMIT      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
  input  logic [MEMORY_DATA_WIDTH-1:0] encoded_data_i,
  output logic                         wr_full_o,
  output logic                         ovf_o,
  input  logic                         rd_req_i,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_i,
  output logic                         rd_stall_o,
  output logic                         fwd_hit_o,
  output logic [MEMORY_DATA_WIDTH-1:0] fwd_data_o,
  output logic                         mem_en_o,
  output logic                         mem_we_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [MEMORY_DATA_WIDTH-1:0] mem_wdata_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0]        addr_q [DEPTH];
  logic [MEMORY_DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [CNT_W-1:0]             count;
  logic [WAIT_W-1:0]            wait_cnt;
  logic                         ovf;

  logic                         full;
  logic                         non_empty;
  logic                         push_ok;
  logic                         grant_wr;
  logic                         match_any;
  logic                         hit_stall;
  logic [PTR_W-1:0]             idx;
`ifdef WRQ_FWD_EN
  logic [MEMORY_DATA_WIDTH-1:0] fwd_data;
`endif

  assign full      = (count == CNT_W'(DEPTH));
  assign non_empty = (count != '0);
  // A pop in the same cycle does not free a slot for the push.
  assign push_ok   = wr_en_i && !full;

  assign wr_full_o = full;
  assign ovf_o     = ovf;
  assign count_o   = count;

  // Entry storage carries no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[tail] <= wr_addr_i;
      data_q[tail] <= encoded_data_i;
    end
  end

  // Walk valid entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    match_any = 1'b0;
    idx       = '0;
`ifdef WRQ_FWD_EN
    fwd_data  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (addr_q[idx] == rd_addr_i)) begin
        match_any = 1'b1;
`ifdef WRQ_FWD_EN
        fwd_data  = data_q[idx];
`endif
      end
    end
  end

`ifdef WRQ_FWD_EN
  assign fwd_hit_o  = match_any;
  assign fwd_data_o = fwd_data;
  assign hit_stall  = 1'b0;
`else
  assign fwd_hit_o  = 1'b0;
  assign fwd_data_o = '0;
  assign hit_stall  = rd_req_i && match_any;
`endif

  // Port arbitration: force, hit-stall, read, drain, idle.
  always_comb begin
    grant_wr    = 1'b0;
    rd_stall_o  = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (non_empty && (wait_cnt == WAIT_W'(STARVE_LIMIT))) begin
      grant_wr   = 1'b1;
      rd_stall_o = rd_req_i;
    end else if (hit_stall) begin
      grant_wr   = 1'b1;
      rd_stall_o = 1'b1;
    end else if (rd_req_i) begin
      mem_en_o   = 1'b1;
      mem_addr_o = rd_addr_i;
    end else if (non_empty) begin
      grant_wr   = 1'b1;
    end
    if (grant_wr) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = addr_q[head];
      mem_wdata_o = data_q[head];
    end
  end

  // Pointers, occupancy, sticky overflow and the starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wait_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push_ok) begin
        tail <= tail + 1'b1;
      end
      if (grant_wr) begin
        head <= head + 1'b1;
      end
      case ({push_ok, grant_wr})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en_i && full) begin
        ovf <= 1'b1;
      end
      if (grant_wr || !non_empty) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_W'(STARVE_LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_wr_queue.md
# mem_wr_queue

Write-side buffer between the ECC data encoder and the ECC SRAM port. Accepts encoded 39-bit codewords with word addresses, holds up to DEPTH pending writes, and drains them into memory whenever the read path is idle. The read path has priority, subject to a starvation limit. Read/write coherence is kept by forwarding, or by stalling when forwarding is compiled out.

## Interface
- MEMORY_DATA_WIDTH, 39, codeword width (32 data + 6 Hamming + 1 overall parity)
- ADDR_WIDTH, 14, word-address width
- DEPTH, 4, queue entries; power of two, minimum 2
- STARVE_LIMIT, 8, consecutive deferred cycles before a write is forced
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en_i  in  1  push request from encoder
- wr_addr_i  in  ADDR_WIDTH  word address of codeword
- encoded_data_i  in  MEMORY_DATA_WIDTH  codeword
- wr_full_o  out  1  queue full; push not accepted
- ovf_o  out  1  sticky: push attempted while full
- rd_req_i  in  1  read path requests the memory port this cycle
- rd_addr_i  in  ADDR_WIDTH  read word address
- rd_stall_o  out  1  read not issued this cycle; read path must hold and retry
- fwd_hit_o  out  1  queued entry matches rd_addr_i (forwarding build only)
- fwd_data_o  out  MEMORY_DATA_WIDTH  youngest matching queued codeword
- mem_en_o  out  1  memory access this cycle
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  MEMORY_DATA_WIDTH  write codeword (head entry)
- count_o  out  $clog2(DEPTH)+1  occupancy

## Operation
- Circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. count_o is a separate counter.
- Push:
  - Accepted when wr_en_i && count_o < DEPTH. Entry is written at the tail.
  - When wr_en_i && full, the push is dropped and ovf_o is set. ovf_o clears only on reset.
- wr_full_o = (count_o == DEPTH), decoded from registered count. A pop in the same cycle does not make room for a push.
- Port arbitration, evaluated each cycle in this priority order:
  1. force: queue non-empty && wait_cnt == STARVE_LIMIT. Write head; rd_stall_o=1 if rd_req_i.
  2. hit-stall (no-forwarding build only): rd_req_i && rd_addr_i matches any valid entry. Write head; rd_stall_o=1.
  3. read: rd_req_i. mem_en_o=1, mem_we_o=0, mem_addr_o=rd_addr_i.
  4. drain: queue non-empty. mem_en_o=1, mem_we_o=1, address and data from head.
  5. idle: mem_en_o=0.
- A write grant pops the head at the clock edge.
- wait_cnt:
  - Increments each cycle the queue is non-empty and no pop occurs.
  - Clears on any pop and whenever the queue is empty.
  - Saturates at STARVE_LIMIT.
- Memory outputs are combinational from the arbitration result and head registers. When mem_en_o=0, mem_we_o, mem_addr_o and mem_wdata_o are 0.
- Forwarding: compare rd_addr_i against all valid entries; the youngest (closest to tail) match wins. An entry being pushed in the current cycle is not visible until the next cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.

## Timing
- Reset values: wr_full_o=0, ovf_o=0, rd_stall_o=0, fwd_hit_o=0, fwd_data_o=0, mem_*=0, count_o=0. Pointers and wait_cnt are 0; entry contents are don't-care.
- Push-to-drain latency: a push at edge N is eligible for the memory port in cycle N+1. An idle port writes it at edge N+1.
- Read grant is same-cycle (combinational). Read data returns from SRAM per SRAM latency and is outside this block.
- Reset asserted mid-operation empties the queue immediately. Pending writes are lost; mem_en_o drops asynchronously.

## Configuration
- WRQ_FWD_EN defined:
  - Forwarding logic is present. fwd_hit_o/fwd_data_o are live.
  - A read hitting a queued address is issued normally; the read path substitutes fwd_data_o.
- WRQ_FWD_EN undefined:
  - fwd_hit_o=0 and fwd_data_o=0 permanently.
  - A hitting read takes hit-stall; queued writes drain until no entry matches, then the read is issued. No stale data is ever returned.

## Test plan
- Reset, then push 4 codewords (addr 0x10..0x13, data 0x1_0000_0001..4) with rd_req_i=0 -> four writes on consecutive cycles in push order; count_o returns to 0.
- Push 5 with rd_req_i held high -> fifth push dropped, wr_full_o=1, ovf_o=1 and sticky. After 8 deferred cycles, cycle 9 forces a write with rd_stall_o=1, then reads resume for 8 more cycles.
- Push addr 0x20 data A then addr 0x20 data B, then rd_addr_i=0x20 with WRQ_FWD_EN -> fwd_hit_o=1, fwd_data_o=B, read issued same cycle.
- Same sequence without WRQ_FWD_EN -> rd_stall_o=1 for 2 cycles while both writes drain, then read issued with mem_we_o=0.
- Push at full with a simultaneous pop -> push refused, count_o=3 next cycle. Run 6 push/pop laps -> pointer wrap preserves order.
- Assert rst_n low with 3 entries queued -> all outputs at reset values immediately; no further mem writes after release.
